// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: three requesters share one regfile write port.
// Define WB_ARB_DROP_X0_EN to retire x0 writes in IDLE without a WRITE cycle.
module regfile_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_register,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  output logic        write_activate,
  input  logic        write_done,
  output logic        busy,
  output logic        timeout_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_ptr;
  logic [1:0]    r_grant;
  logic [1:0]    w_ptr_nxt;
  logic [1:0]    w_sel;
  logic [1:0]    w_c1;
  logic [1:0]    w_c2;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_wreg;
  logic [4:0]    w_reg;
  logic [31:0]   r_wdata;
  logic [31:0]   w_data;
  logic          r_terr;
  logic          w_load;
  logic          w_abort;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // First valid requester at or after the pointer, wrapping mod 3
  always_comb begin
    w_c1 = inc3(r_ptr);
    w_c2 = inc3(w_c1);
    if (req_valid[r_ptr])     w_sel = r_ptr;
    else if (req_valid[w_c1]) w_sel = w_c1;
    else                      w_sel = w_c2;
  end

  always_comb begin
    unique case (w_sel)
      2'd1: begin
        w_reg  = req_register[9:5];
        w_data = req_data[63:32];
      end
      2'd2: begin
        w_reg  = req_register[14:10];
        w_data = req_data[95:64];
      end
      default: begin
        w_reg  = req_register[4:0];
        w_data = req_data[31:0];
      end
    endcase
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 3'b000;
    w_load    = 1'b0;
    w_abort   = 1'b0;
    w_ptr_nxt = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
`ifdef WB_ARB_DROP_X0_EN
          if (w_reg == 5'd0) begin
            req_ready[w_sel] = 1'b1;
            w_ptr_nxt        = inc3(w_sel);
          end else begin
            w_next = S_WRITE;
            w_load = 1'b1;
          end
`else
          w_next = S_WRITE;
          w_load = 1'b1;
`endif
        end
      end
      S_WRITE: begin
        if (write_done) begin
          req_ready[r_grant] = 1'b1;
          w_next             = S_IDLE;
          w_ptr_nxt          = inc3(r_grant);
        end else if (r_cnt == LAST) begin
          w_next    = S_IDLE;
          w_abort   = 1'b1;
          w_ptr_nxt = inc3(r_grant);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_grant <= 2'd0;
      r_cnt   <= '0;
      r_wreg  <= 5'd0;
      r_wdata <= 32'd0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr_nxt;
      if (w_load) begin
        r_grant <= w_sel;
        r_wreg  <= w_reg;
        r_wdata <= w_data;
        r_cnt   <= '0;
      end else if (r_state == S_WRITE && !write_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_abort) r_terr <= 1'b1;
    end
  end

  assign write_activate = (r_state == S_WRITE);
  assign busy           = (r_state == S_WRITE);
  assign write_register = r_wreg;
  assign write_data     = r_wdata;
  assign timeout_error  = r_terr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed steps plus random traffic
// against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_register;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_activate;
  logic        write_done;
  logic        busy;
  logic        timeout_error;

  logic done_tie;
  logic done_val;
  assign write_done = done_tie ? write_activate : done_val;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_register(req_register),
    .req_data(req_data),
    .req_ready(req_ready),
    .write_register(write_register),
    .write_data(write_data),
    .write_activate(write_activate),
    .write_done(write_done),
    .busy(busy),
    .timeout_error(timeout_error)
  );

  int errors = 0;
  int checks = 0;

  // reference model: one pending write at a time, pointer-based fairness
  logic        m_busy;
  int          m_grant;
  int          m_ptr;
  int          m_cyc;
  logic        m_err;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  logic [2:0] last_ready;
  logic [2:0] ready_acc;
  bit hold_valid;
  bit auto_req;
  bit scramble;
  int act_cnt;
  int cyc_n;
  int grants[$];
  int gtimes[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_busy     = 1'b0;
    m_grant    = 0;
    m_ptr      = 0;
    m_cyc      = 0;
    m_err      = 1'b0;
    last_ready = 3'b000;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " act"},   write_activate, 0);
    chk({tag, " busy"},  busy, 0);
    chk({tag, " ready"}, req_ready, 0);
    chk({tag, " wreg"},  write_register, 0);
    chk({tag, " wdata"}, write_data, 0);
    chk({tag, " terr"},  timeout_error, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    m_reset();
    chk_reset_vals("reset");
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (last_ready[i] && !hold_valid) req_valid[i] = 1'b0;
    if (auto_req) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i]          = 1'b1;
          req_register[5*i +: 5] = 5'($urandom);
          req_data[32*i +: 32]   = $urandom;
        end
      end
      done_val = ($urandom_range(2, 0) == 0);
    end
    if (scramble && m_busy && $urandom_range(1, 0) == 1)
      req_data[32*m_grant +: 32] = $urandom;
  endtask

  task automatic cyc_check();
    int g;
    int j;
    logic [2:0] e_ready;
    logic done_now;
    #1;
    cyc_n++;
    done_now = done_tie ? m_busy : done_val;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      j = (m_ptr + k) % 3;
      if (g < 0 && req_valid[j]) g = j;
    end
    e_ready = 3'b000;
    if (m_busy) begin
      if (done_now) e_ready[m_grant] = 1'b1;
    end
`ifdef WB_ARB_DROP_X0_EN
    else if (g >= 0 && req_register[5*g +: 5] == 5'd0) e_ready[g] = 1'b1;
`endif
    chk("act", write_activate, m_busy);
    chk("busy", busy, m_busy);
    chk("ready", req_ready, e_ready);
    chk("terr", timeout_error, m_err);
    if (m_busy) begin
      chk("wreg", write_register, m_reg);
      chk("wdata", write_data, m_data);
    end
    if (write_activate === 1'b1) act_cnt++;
    ready_acc  = ready_acc | req_ready;
    last_ready = req_ready;
    if (req_ready != 3'b000) begin
      grants.push_back(req_ready[0] ? 0 : (req_ready[1] ? 1 : 2));
      gtimes.push_back(cyc_n);
    end
    if (m_busy) begin
      if (done_now) begin
        m_busy = 1'b0;
        m_ptr  = (m_grant + 1) % 3;
      end else if (m_cyc + 1 == TO) begin
        m_busy = 1'b0;
        m_err  = 1'b1;
        m_ptr  = (m_grant + 1) % 3;
      end else begin
        m_cyc++;
      end
    end else if (g >= 0) begin
`ifdef WB_ARB_DROP_X0_EN
      if (req_register[5*g +: 5] == 5'd0) m_ptr = (g + 1) % 3;
      else
`endif
      begin
        m_busy  = 1'b1;
        m_grant = g;
        m_cyc   = 0;
        m_reg   = req_register[5*g +: 5];
        m_data  = req_data[32*g +: 32];
      end
    end
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_check();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 3'b000;
    req_register = '0;
    req_data     = '0;
    done_tie     = 1'b0;
    done_val     = 1'b0;
    hold_valid   = 1'b0;
    auto_req     = 1'b0;
    scramble     = 1'b0;
    act_cnt      = 0;
    cyc_n        = 0;
    ready_acc    = 3'b000;
    m_reg        = '0;
    m_data       = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #2;
    chk_reset_vals("por");
    @(posedge clk);
    #2 rst = 1'b0;

    // single ALU write, done tied to activate
    done_tie = 1'b1;
    act_cnt  = 0;
    cyc_begin();
    req_valid         = 3'b001;
    req_register[4:0] = 5'd1;
    req_data[31:0]    = 32'hdead_beef;
    cyc_check();
    cycle();
    chk("alu wreg", write_register, 5'd1);
    chk("alu wdata", write_data, 32'hdead_beef);
    chk("alu ready", req_ready, 3'b001);
    cycle();
    chk("alu busy after", busy, 0);
    chk("alu act count", act_cnt, 1);

    // all three continuously valid from reset
    do_reset();
    grants.delete();
    gtimes.delete();
    hold_valid = 1'b1;
    cyc_begin();
    req_valid    = 3'b111;
    req_register = {5'd4, 5'd3, 5'd2};
    req_data     = {32'hcccc_0002, 32'hbbbb_0001, 32'haaaa_0000};
    cyc_check();
    repeat (7) cycle();
    hold_valid = 1'b0;
    cyc_begin();
    req_valid = 3'b000;
    cyc_check();
    chk("rr count", grants.size(), 4);
    if (grants.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr order", grants[k], k % 3);
      for (int k = 1; k < 4; k++) chk("rr gap", gtimes[k] - gtimes[k-1], 2);
    end

    // load write with done withheld for five cycles
    done_tie = 1'b0;
    done_val = 1'b0;
    cyc_begin();
    req_valid          = 3'b010;
    req_register[9:5]  = 5'd7;
    req_data[63:32]    = 32'h0bad_cafe;
    cyc_check();
    act_cnt   = 0;
    ready_acc = 3'b000;
    cycle();
    cycle();
    cyc_begin();
    req_valid[1]    = 1'b0;
    req_data[63:32] = 32'h1111_2222;
    cyc_check();
    cycle();
    cycle();
    chk("load no early ready", ready_acc, 0);
    cyc_begin();
    done_val = 1'b1;
    cyc_check();
    chk("load ready", req_ready, 3'b010);
    chk("load wdata", write_data, 32'h0bad_cafe);
    cyc_begin();
    done_val = 1'b0;
    cyc_check();
    chk("load act count", act_cnt, 6);
    chk("load terr", timeout_error, 0);

    // write to x0
    done_tie = 1'b1;
    act_cnt  = 0;
    cyc_begin();
    req_valid           = 3'b100;
    req_register[14:10] = 5'd0;
    req_data[95:64]     = 32'hffff_ffff;
    cyc_check();
`ifdef WB_ARB_DROP_X0_EN
    chk("x0 idle ready", req_ready, 3'b100);
`endif
    cycle();
`ifndef WB_ARB_DROP_X0_EN
    chk("x0 wreg", write_register, 5'd0);
    chk("x0 wdata", write_data, 32'hffff_ffff);
    chk("x0 ready", req_ready, 3'b100);
`endif
    cycle();
`ifdef WB_ARB_DROP_X0_EN
    chk("x0 act count", act_cnt, 0);
`else
    chk("x0 act count", act_cnt, 1);
`endif

    // timeout abort, then next requester granted
    done_tie = 1'b0;
    done_val = 1'b0;
    cyc_begin();
    req_valid          = 3'b011;
    req_register[4:0]  = 5'd9;
    req_register[9:5]  = 5'd10;
    req_data[31:0]     = 32'h0000_0009;
    req_data[63:32]    = 32'h0000_000a;
    cyc_check();
    act_cnt   = 0;
    ready_acc = 3'b000;
    repeat (TO) cycle();
    chk("to act count", act_cnt, TO);
    cycle();
    chk("to terr set", timeout_error, 1);
    chk("to no ready", ready_acc, 0);
    chk("to idle", busy, 0);
    cyc_begin();
    done_val = 1'b1;
    cyc_check();
    chk("to next wreg", write_register, 5'd10);
    chk("to next ready", req_ready, 3'b010);
    cycle();
    cycle();
    cycle();
    done_val = 1'b0;
    chk("to terr sticky", timeout_error, 1);

    // reset during the second WRITE cycle
    cyc_begin();
    req_valid         = 3'b010;
    req_register[9:5] = 5'd5;
    req_data[63:32]   = 32'h1234_5678;
    cyc_check();
    cycle();
    cycle();
    chk("rst pre act", write_activate, 1);
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk_reset_vals("midrst");
    @(posedge clk);
    #2 rst = 1'b0;
    cycle();
    cycle();
    chk("regrant wreg", write_register, 5'd5);
    chk("regrant wdata", write_data, 32'h1234_5678);
    cyc_begin();
    done_val = 1'b1;
    cyc_check();
    chk("regrant ready", req_ready, 3'b010);
    cycle();
    done_val = 1'b0;

    // random traffic
    auto_req = 1'b1;
    scramble = 1'b1;
    repeat (600) cycle();
    auto_req = 1'b0;
    scramble = 1'b0;
    repeat (30) begin
      cyc_begin();
      done_val = 1'b1;
      cyc_check();
    end
    chk("drain idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum write_done wait, in cycles, before a write is aborted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  3  writeback request per requester (bit 0 ALU, bit 1 load, bit 2 CSR).
REQ-005 SHALL have port req_register  input  15  destination index per requester; bits [5i+4:5i] belong to requester i.
REQ-006 SHALL have port req_data  input  96  write data per requester; bits [32i+31:32i] belong to requester i.
REQ-007 SHALL have port req_ready  output  3  one-hot completion strobe to requester i.
REQ-008 SHALL have port write_register  output  5  register-file write index.
REQ-009 SHALL have port write_data  output  32  register-file write data.
REQ-010 SHALL have port write_activate  output  1  register-file write enable.
REQ-011 SHALL have port write_done  input  1  register-file write acknowledge.
REQ-012 SHALL have port busy  output  1  high while state is WRITE.
REQ-013 SHALL have port timeout_error  output  1  sticky flag; set on abort, cleared only by rst.

Function
REQ-014 SHALL implement FSM states IDLE and WRITE.
REQ-015 IDLE: with any req_valid bit set, SHALL grant one requester round-robin and latch its register/data into write_register/write_data; next state WRITE.
REQ-016 Round-robin: search SHALL start at pointer rr_ptr and ascend modulo 3; rr_ptr SHALL become grant+1 mod 3 on each completion or abort.
REQ-017 WRITE: write_activate SHALL be 1; write_register and write_data SHALL stay stable.
REQ-018 WRITE with write_done=1: req_ready[grant] SHALL be 1 combinationally in that cycle; next state IDLE.
REQ-019 Handshake: requester SHALL hold valid and payload until ready; a change in the payload of a granted requester mid-WRITE SHALL NOT affect the write port.
REQ-020 Minimum latency: valid seen in cycle N → write_activate in N+1 → req_ready in N+1 if write_done is already high; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-021 Wait counter: SHALL clear on WRITE entry and increment each WRITE cycle without write_done; at TIMEOUT_CYCLES it SHALL abort: no req_ready, timeout_error set, state IDLE, rr_ptr advanced.
REQ-022 In IDLE, write_activate SHALL be 0 and req_ready SHALL be 0, except as given by REQ-027.
REQ-023 A deasserted req_valid of the granted requester during WRITE SHALL NOT abort the write.

Reset
REQ-024 rst SHALL force, asynchronously: state IDLE, rr_ptr 0, wait counter 0, write_register 0, write_data 0, write_activate 0, req_ready 0, busy 0, timeout_error 0.
REQ-025 rst asserted mid-WRITE SHALL drop write_activate immediately; the in-flight requester receives no ready and re-requests after reset.

Configuration
REQ-026 Macro WB_ARB_DROP_X0_EN SHALL select x0 handling.
REQ-027 With WB_ARB_DROP_X0_EN defined: a granted request whose register is 5'd0 SHALL get req_ready in the IDLE cycle, with no write_activate and no WRITE entry; rr_ptr SHALL advance.
REQ-028 Without WB_ARB_DROP_X0_EN: x0 requests SHALL be treated like any other register; the register file discards them.

Verification
REQ-029 Single request, ALU reg 1 data 32'hdead_beef, write_done tied to write_activate: write_activate 1 for one cycle with index 1/data deadbeef; req_ready=3'b001 in the same cycle; busy 1 for that cycle only.
REQ-030 All three valid continuously from reset, immediate write_done: grants in order 0,1,2,0 with one IDLE cycle between each.
REQ-031 Load request, write_done withheld 5 cycles: write_activate high 6 cycles; req_ready=3'b010 only in the 6th; timeout_error 0.
REQ-032 write_done held 0, TIMEOUT_CYCLES=16: abort after 16 WRITE cycles; timeout_error 1 and sticky; no ready; next requester granted.
REQ-033 rst pulsed on the 2nd WRITE cycle: write_activate drops 0 within the reset cycle; all outputs at reset values; the request is re-granted after rst falls.
REQ-034 Request to reg 0 with data 32'hffff_ffff: with the macro, ready in the IDLE cycle and write_activate never 1; without it, a normal WRITE cycle; a register-file read of x0 returns 0 in both builds.
